// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver oversampled at `prescale` clocks per bit.
//               Receives LSB-first 8-bit frames with optional even/odd parity,
//               one stop bit and one mandatory idle (guard) bit. Each good
//               byte is presented on parallel_data with a one-cycle
//               data_valid strobe. Bad frames are dropped silently.
// Ports       : clk_based_on_prescale  oversampling clock (rising edge)
//               asy_reset              asynchronous reset, active low
//               RX_IN                  serial line, idle high, pre-synchronised
//               prescale[5:0]          clocks per bit (8, 16 or 32)
//               parity_enable          1 = parity bit follows the data
//               parity_type            0 = even, 1 = odd
//               parallel_data[7:0]     last correctly received byte
//               data_valid             one-cycle new-byte strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx (
    input  logic       clk_based_on_prescale,
    input  logic       asy_reset,
    input  logic       RX_IN,
    input  logic [5:0] prescale,
    input  logic       parity_enable,
    input  logic       parity_type,
    output logic [7:0] parallel_data,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GUARD  = 3'd5
    } state_t;

    state_t     r_state;
    logic [5:0] r_prescale;   // frame configuration latched at start detect
    logic       r_par_en;
    logic       r_par_type;
    logic [5:0] r_cnt;        // in-bit edge count of the edge being processed
    logic [2:0] r_samples;    // the three mid-bit samples of the current bit
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_done;       // guard complete; output registers load next edge

    logic [5:0] w_half;
    logic       w_sample_pt;
    logic       w_bit_end;
    logic       w_bit_val;
    logic       w_par_exp;

    assign w_half      = r_prescale >> 1;
    assign w_sample_pt = (r_cnt == (w_half - 6'd1)) ||
                         (r_cnt == w_half) ||
                         (r_cnt == (w_half + 6'd1));
    // With a 6-bit counter a bit never lasts more than 64 edges, which keeps
    // any frame (even with a nonsense prescale) bounded to 12 * 64 cycles.
    assign w_bit_end   = (r_cnt == (r_prescale - 6'd1));
    assign w_bit_val   = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);
    assign w_par_exp   = (^r_shift) ^ r_par_type;

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            r_state       <= S_IDLE;
            r_prescale    <= 6'd0;
            r_par_en      <= 1'b0;
            r_par_type    <= 1'b0;
            r_cnt         <= 6'd0;
            r_samples     <= 3'd0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_done        <= 1'b0;
            parallel_data <= 8'h00;
            data_valid    <= 1'b0;
        end else begin
            // Strobe is registered one edge after guard completion.
            r_done     <= 1'b0;
            data_valid <= r_done;
            if (r_done) begin
                parallel_data <= r_shift;
            end

            case (r_state)
                S_IDLE: begin
                    if (!RX_IN) begin
                        // This edge is count 0 of the start bit.
                        r_state    <= S_START;
                        r_cnt      <= 6'd1;
                        r_bit_idx  <= 3'd0;
                        r_prescale <= prescale;
                        r_par_en   <= parity_enable;
                        r_par_type <= parity_type;
                    end
                end
                default: begin
                    if (w_sample_pt) begin
                        r_samples <= {r_samples[1:0], RX_IN};
                    end
                    if (w_bit_end) begin
                        r_cnt <= 6'd0;
                        case (r_state)
                            S_START: begin
                                r_state <= w_bit_val ? S_IDLE : S_DATA;
                            end
                            S_DATA: begin
                                r_shift   <= {w_bit_val, r_shift[7:1]};
                                r_bit_idx <= r_bit_idx + 3'd1;
                                if (r_bit_idx == 3'd7) begin
                                    r_state <= r_par_en ? S_PARITY : S_STOP;
                                end
                            end
                            S_PARITY: begin
                                r_state <= (w_bit_val == w_par_exp) ? S_STOP : S_IDLE;
                            end
                            S_STOP: begin
                                r_state <= w_bit_val ? S_GUARD : S_IDLE;
                            end
                            S_GUARD: begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx. Inputs change on
//               the falling edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk_based_on_prescale = 1'b0;
    logic       asy_reset;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] parallel_data;
    logic       data_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;

    uart_rx dut (
        .clk_based_on_prescale (clk_based_on_prescale),
        .asy_reset             (asy_reset),
        .RX_IN                 (RX_IN),
        .prescale              (prescale),
        .parity_enable         (parity_enable),
        .parity_type           (parity_type),
        .parallel_data         (parallel_data),
        .data_valid            (data_valid)
    );

    always #5 clk_based_on_prescale = ~clk_based_on_prescale;

    // Counts every cycle in which the strobe is high.
    always @(posedge clk_based_on_prescale) begin
        if (data_valid === 1'b1) pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge clk_based_on_prescale);
    endtask

    // Full frame plus guard bit. Leaves the caller at the falling edge that
    // follows edge (N+1)*P-1. Config inputs are scrambled right after the
    // start-detect edge to confirm they are latched.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pt, input logic par_bit, input logic stop_bit);
        prescale      = 6'(p);
        parity_enable = pe;
        parity_type   = pt;
        RX_IN         = 1'b0;
        @(negedge clk_based_on_prescale);
        prescale      = (p == 8) ? 6'd16 : 6'd8;
        parity_enable = ~pe;
        parity_type   = ~pt;
        repeat (p - 1) @(negedge clk_based_on_prescale);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        drive_bit(1'b1, p);
    endtask

    task automatic expect_good(input string tag, input logic [7:0] d);
        check({tag, "_dv_before"}, 32'(data_valid), 32'd0);
        @(negedge clk_based_on_prescale);
        check({tag, "_dv_pulse"}, 32'(data_valid), 32'd1);
        check({tag, "_data"}, 32'(parallel_data), 32'(d));
        @(negedge clk_based_on_prescale);
        check({tag, "_dv_after"}, 32'(data_valid), 32'd0);
        check({tag, "_data_hold"}, 32'(parallel_data), 32'(d));
    endtask

    initial begin
        asy_reset     = 1'b0;
        RX_IN         = 1'b1;
        prescale      = 6'd8;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        repeat (3) @(negedge clk_based_on_prescale);
        check("reset_data", 32'(parallel_data), 32'h00);
        check("reset_dv", 32'(data_valid), 32'd0);
        asy_reset = 1'b1;
        repeat (5) @(negedge clk_based_on_prescale);

        // 8N1, P=8, 0xA5: strobe at edge 88 after start detect
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_good("a5_8n1", 8'hA5);
        check("a5_pulses", 32'(pulses), 32'd1);

        // 8E1, P=16, 0x5A, parity 0
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_good("5a_8e1", 8'h5A);

        // 8E1, P=32, 0x3C with wrong parity 1: dropped
        base = pulses;
        send_frame(8'h3C, 32, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (100) @(negedge clk_based_on_prescale);
        check("par_err_pulses", 32'(pulses), 32'(base));
        check("par_err_data", 32'(parallel_data), 32'h5A);

        // 8N1, P=8, 0xFF with stop 0: framing error, then recovery
        base = pulses;
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk_based_on_prescale);
        check("frm_err_pulses", 32'(pulses), 32'(base));
        check("frm_err_data", 32'(parallel_data), 32'h5A);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_good("81_recover", 8'h81);

        // 8N1, P=16, 0x00
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_good("00_8n1", 8'h00);

        // Half-bit low glitch at P=16: start rejected, no strobe
        base = pulses;
        prescale      = 6'd16;
        parity_enable = 1'b1;
        parity_type   = 1'b1;
        RX_IN         = 1'b0;
        repeat (8) @(negedge clk_based_on_prescale);
        RX_IN = 1'b1;
        repeat (40) @(negedge clk_based_on_prescale);
        check("glitch_pulses", 32'(pulses), 32'(base));

        // 8O1, P=16, 0x37 (five ones -> parity bit 0)
        send_frame(8'h37, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_good("37_8o1", 8'h37);

        // Reset mid-frame: outputs cleared, frame aborted
        base = pulses;
        prescale = 6'd16;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        asy_reset = 1'b0;
        #1;
        check("midreset_data", 32'(parallel_data), 32'h00);
        check("midreset_dv", 32'(data_valid), 32'd0);
        RX_IN = 1'b1;
        repeat (3) @(negedge clk_based_on_prescale);
        asy_reset = 1'b1;
        repeat (40) @(negedge clk_based_on_prescale);
        check("midreset_pulses", 32'(pulses), 32'(base));

        // 8O1, P=16, 0xC3 (four ones -> parity bit 1)
        send_frame(8'hC3, 16, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_good("c3_8o1", 8'hC3);
        check("final_pulses", 32'(pulses), 32'(base + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
